// File: rtl/trdb_pkg.sv
// Shared types for the trace debugger memory writer.
// Word width, word type and the writer FSM states.
package trdb_pkg;

    localparam int unsigned TRDB_WORD_LEN = 32;

    typedef logic [TRDB_WORD_LEN-1:0] trdb_word_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        STOPPED
    } trdb_wr_state_e;

endpackage

// File: rtl/trdb_word_fifo.sv
// Generic synchronous word FIFO with clear; DEPTH must be a power of 2.
// Caller guarantees no push when full (unless popping) and no pop when empty.
module trdb_word_fifo
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  trdb_word_t                 data_i,
    input  logic                       pop_i,
    output trdb_word_t                 data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    trdb_word_t    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (pop_i)  rd_d = rd_q + AW'(1);
            if (push_i && !pop_i) cnt_d = cnt_q + (AW+1)'(1);
            if (!push_i && pop_i) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/trdb_tcdm_writer.sv
// Writes aligned trace words into a circular memory buffer over a req/gnt port.
// Define TRDB_OVERFLOW_CNT_EN to add the saturating overflow_cnt_o counter.
module trdb_tcdm_writer
    import trdb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BUF_SIZE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           data_i,
    input  logic                  valid_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  wrap_en_i,
    input  logic [31:0]           buf_base_i,
    input  logic [BUF_SIZE_W-1:0] buf_size_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [BUF_SIZE_W-1:0] wr_ptr_o,
    output logic                  wrapped_o,
    output logic                  full_o,
    output logic                  overflow_o
`ifdef TRDB_OVERFLOW_CNT_EN
    ,
    output logic [15:0]           overflow_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    trdb_wr_state_e        state_q, state_d;
    logic [BUF_SIZE_W-1:0] ptr_q, ptr_d;
    logic                  wrapped_q, wrapped_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;

    logic       fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    trdb_word_t fifo_head;

    logic in_word, push, pop, drop, last_idx, empty_nxt;

    assign in_word  = valid_i && enable_i && !clear_i;
    assign pop      = (state_q == WRITE) && mem_gnt_i && !clear_i;
    assign push     = in_word && (state_q != STOPPED) && (!fifo_full || pop);
    assign drop     = in_word && !push;
    assign last_idx = (ptr_q == buf_size_i - BUF_SIZE_W'(1));

    // FIFO occupancy after this cycle's push/pop
    assign empty_nxt = (fifo_cnt == CW'(0) && !push) ||
                       (fifo_cnt == CW'(1) && pop && !push);

    trdb_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        full_d    = full_q;
        ovf_d     = drop;
        if (clear_i) begin
            state_d   = IDLE;
            ptr_d     = '0;
            wrapped_d = 1'b0;
            full_d    = 1'b0;
        end else if (state_q != STOPPED) begin
            state_d = empty_nxt ? IDLE : WRITE;
            if (pop) begin
                if (last_idx) begin
                    ptr_d     = '0;
                    wrapped_d = 1'b1;
                    if (!wrap_en_i) begin
                        full_d  = 1'b1;
                        state_d = STOPPED;
                    end
                end else begin
                    ptr_d = ptr_q + BUF_SIZE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wrapped_q <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef TRDB_OVERFLOW_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear_i) begin
            ovf_cnt_d = '0;
        end else if (drop && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign overflow_cnt_o = ovf_cnt_q;
`endif

    assign mem_req_o    = (state_q == WRITE);
    assign mem_addr_o   = buf_base_i + 32'({ptr_q, 2'b00});
    assign mem_wdata_o  = fifo_head;
    assign mem_we_o     = 1'b1;
    assign mem_be_o     = 4'hF;
    assign wr_ptr_o     = ptr_q;
    assign wrapped_o    = wrapped_q;
    assign full_o       = full_q;
    assign overflow_o   = ovf_q;
    assign flush_done_o = flush_i &&
                          ((fifo_empty && !mem_req_o) || state_q == STOPPED);

endmodule

// File: tb/tb_trdb_tcdm_writer.sv
// Scoreboard bench for trdb_tcdm_writer: directed words, queued expected writes.
// A negedge monitor checks every granted write and stall stability.
module tb_trdb_tcdm_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic        valid_i, enable_i, clear_i, wrap_en_i;
    logic [31:0] buf_base_i;
    logic [15:0] buf_size_i;
    logic        flush_i, flush_done_o;
    logic        mem_req_o, mem_gnt_i;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [15:0] wr_ptr_o;
    logic        wrapped_o, full_o, overflow_o;
`ifdef TRDB_OVERFLOW_CNT_EN
    logic [15:0] overflow_cnt_o;
`endif

    always #5 clk = ~clk;

    trdb_tcdm_writer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .wrap_en_i    (wrap_en_i),
        .buf_base_i   (buf_base_i),
        .buf_size_i   (buf_size_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .wr_ptr_o     (wr_ptr_o),
        .wrapped_o    (wrapped_o),
        .full_o       (full_o),
        .overflow_o   (overflow_o)
`ifdef TRDB_OVERFLOW_CNT_EN
        ,
        .overflow_cnt_o (overflow_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;
    int ovf_seen = 0;
    logic [63:0] exp_q [$];

    logic        stall_q = 1'b0;
    logic [31:0] prev_addr, prev_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (overflow_o) ovf_seen++;
            if (stall_q) begin
                check("stall_req", {31'd0, mem_req_o}, 32'd1);
                check("stall_addr", mem_addr_o, prev_addr);
                check("stall_data", mem_wdata_o, prev_data);
            end
            if (mem_req_o && mem_gnt_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h",
                             mem_addr_o, mem_wdata_o);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr_o, e[63:32]);
                    check("wr_data", mem_wdata_o, e[31:0]);
                end
            end
            stall_q   = mem_req_o && !mem_gnt_i;
            prev_addr = mem_addr_o;
            prev_data = mem_wdata_o;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] d);
        valid_i = 1'b1;
        data_i  = d;
        cyc(1);
        valid_i = 1'b0;
    endtask

    task automatic expect_wr(logic [31:0] a, logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_idle(string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !mem_req_o) break;
            cyc(1);
        end
        if (i == 200) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s_timeout: pending %0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        data_i = '0; valid_i = 0; enable_i = 0; clear_i = 0;
        wrap_en_i = 1; buf_base_i = 32'h1000; buf_size_i = 16'd8;
        flush_i = 0; mem_gnt_i = 1;
        #12;
        check("rst_req", {31'd0, mem_req_o}, 0);
        check("rst_ptr", {16'd0, wr_ptr_o}, 0);
        check("rst_wrapped", {31'd0, wrapped_o}, 0);
        check("rst_full", {31'd0, full_o}, 0);
        check("rst_ovf", {31'd0, overflow_o}, 0);
        check("rst_flush_done", {31'd0, flush_done_o}, 0);
        cyc(1);
        rst = 1'b0;
        enable_i = 1'b1;
        cyc(1);

        // 1: three words, 1 word/cycle, one-cycle latency
        expect_wr(32'h1000, 32'hA0);
        expect_wr(32'h1004, 32'hA1);
        expect_wr(32'h1008, 32'hA2);
        send(32'hA0);
        check("t1_latency_req", {31'd0, mem_req_o}, 1);
        check("t1_first_addr", mem_addr_o, 32'h1000);
        check("t1_we_be", {27'd0, mem_we_o, mem_be_o}, 32'h1F);
        send(32'hA1);
        send(32'hA2);
        wait_idle("t1");
        check("t1_ptr", {16'd0, wr_ptr_o}, 3);

        // 2: wrap with size 4
        do_clear();
        buf_size_i = 16'd4;
        wrap_en_i  = 1'b1;
        expect_wr(32'h1000, 32'hB0);
        expect_wr(32'h1004, 32'hB1);
        expect_wr(32'h1008, 32'hB2);
        expect_wr(32'h100C, 32'hB3);
        expect_wr(32'h1000, 32'hB4);
        expect_wr(32'h1004, 32'hB5);
        for (int i = 0; i < 6; i++) send(32'hB0 + i);
        wait_idle("t2");
        check("t2_wrapped", {31'd0, wrapped_o}, 1);
        check("t2_ptr", {16'd0, wr_ptr_o}, 2);

        // 3: stop on full buffer
        do_clear();
        wrap_en_i = 1'b0;
        ovf_seen  = 0;
        expect_wr(32'h1000, 32'hC0);
        expect_wr(32'h1004, 32'hC1);
        expect_wr(32'h1008, 32'hC2);
        expect_wr(32'h100C, 32'hC3);
        for (int i = 0; i < 6; i++) begin
            send(32'hC0 + i);
            cyc(1);
        end
        cyc(3);
        wait_idle("t3");
        check("t3_full", {31'd0, full_o}, 1);
        check("t3_ovf_pulses", ovf_seen, 2);
        check("t3_no_req", {31'd0, mem_req_o}, 0);
        check("t3_ptr", {16'd0, wr_ptr_o}, 0);
`ifdef TRDB_OVERFLOW_CNT_EN
        check("t3_ovf_cnt", {16'd0, overflow_cnt_o}, 2);
`endif
        flush_i = 1'b1;
        #1;
        check("t3_flush_stopped", {31'd0, flush_done_o}, 1);
        flush_i = 1'b0;

        // 4: stall with full FIFO, two drops, then drain in order
        do_clear();
        wrap_en_i  = 1'b1;
        buf_size_i = 16'd16;
        mem_gnt_i  = 1'b0;
        ovf_seen   = 0;
        expect_wr(32'h1000, 32'hD0);
        expect_wr(32'h1004, 32'hD1);
        expect_wr(32'h1008, 32'hD2);
        expect_wr(32'h100C, 32'hD3);
        for (int i = 0; i < 6; i++) send(32'hD0 + i);
        cyc(10);
        check("t4_ovf_pulses", ovf_seen, 2);
        check("t4_stall_req", {31'd0, mem_req_o}, 1);
        check("t4_stall_addr", mem_addr_o, 32'h1000);
        mem_gnt_i = 1'b1;
        wait_idle("t4");
        check("t4_ptr", {16'd0, wr_ptr_o}, 4);

        // 5: push into full FIFO while popping
        do_clear();
        buf_size_i = 16'd6;
        mem_gnt_i  = 1'b0;
        ovf_seen   = 0;
        for (int i = 0; i < 5; i++) expect_wr(32'h1000 + 4 * i, 32'hE0 + i);
        for (int i = 0; i < 4; i++) send(32'hE0 + i);
        valid_i   = 1'b1;
        data_i    = 32'hE4;
        mem_gnt_i = 1'b1;
        cyc(1);
        valid_i = 1'b0;
        wait_idle("t5");
        check("t5_no_ovf", ovf_seen, 0);
        check("t5_ptr", {16'd0, wr_ptr_o}, 5);

        // 6: flush two queued words across a wrap, then clear
        mem_gnt_i = 1'b0;
        expect_wr(32'h1014, 32'hF0);
        expect_wr(32'h1000, 32'hF1);
        send(32'hF0);
        send(32'hF1);
        flush_i = 1'b1;
        cyc(1);
        check("t6_flush_pending", {31'd0, flush_done_o}, 0);
        mem_gnt_i = 1'b1;
        cyc(1);
        check("t6_flush_one_left", {31'd0, flush_done_o}, 0);
        cyc(1);
        check("t6_flush_done", {31'd0, flush_done_o}, 1);
        check("t6_wrapped", {31'd0, wrapped_o}, 1);
        check("t6_ptr", {16'd0, wr_ptr_o}, 1);
        flush_i = 1'b0;
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'hFF;
        cyc(1);
        clear_i = 1'b0;
        valid_i = 1'b0;
        check("t6_clr_ptr", {16'd0, wr_ptr_o}, 0);
        check("t6_clr_wrapped", {31'd0, wrapped_o}, 0);
        cyc(2);
        check("t6_clr_drop_req", {31'd0, mem_req_o}, 0);
        check("t6_clr_no_ovf", ovf_seen, 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
